// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps a shared ALU/memory datapath through FETCH, DECODE, EXEC, MEM and WB.
// Optional feature macro: MULTICYCLE_JAL_EN makes opcode 1101111 legal and executes it as JAL.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_R      = 3'd1,
        C_I      = 3'd2,
        C_LOAD   = 3'd3,
        C_STORE  = 3'd4,
        C_BRANCH = 3'd5,
        C_JAL    = 3'd6
    } iclass_t;

    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    // Memory handshake: mem_req stays high in FETCH/MEM until mem_ready is seen high
    // on a rising edge; the cycle carrying mem_ready completes the access.

    state_t     state_q, state_d;
    iclass_t    cls_q, dec_class;
    logic [7:0] wait_q;
    logic       fault_q;
    logic       timed_out;
    logic       next_instr;

    always_comb begin
        dec_class = C_NONE;
        case (opcode)
            7'b0110011: dec_class = C_R;
            7'b0010011: dec_class = C_I;
            7'b0000011: dec_class = C_LOAD;
            7'b0100011: dec_class = C_STORE;
            7'b1100011: dec_class = C_BRANCH;
`ifdef MULTICYCLE_JAL_EN
            7'b1101111: dec_class = C_JAL;
`endif
            default:    dec_class = C_NONE;
        endcase
    end

    // A ready arriving in the limit cycle still wins over the timeout.
    assign timed_out  = (wait_q == TIMEOUT) && !mem_ready;
    assign next_instr = run;

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'b00;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        retire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                state_d = (dec_class == C_NONE) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_I: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_op   = 2'b01;
                        pc_src   = 2'b01;
                        pc_write = alu_zero;
                        retire   = 1'b1;
                        state_d  = next_instr ? S_FETCH : S_IDLE;
                    end
`ifdef MULTICYCLE_JAL_EN
                    C_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = 2'b10;
                        state_d  = S_WB;
                    end
`endif
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        retire  = 1'b1;
                        state_d = next_instr ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timed_out) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                if (cls_q == C_LOAD) wb_sel = 2'b01;
`ifdef MULTICYCLE_JAL_EN
                if (cls_q == C_JAL) wb_sel = 2'b10;
`endif
                state_d = next_instr ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
            wait_q  <= 8'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_class;
            // Counts only cycles spent waiting in the same memory state; any move clears it.
            if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && state_d == state_q)
                wait_q <= wait_q + 8'd1;
            else
                wait_q <= 8'd0;
            if (state_d == S_HALT) fault_q <= 1'b1;
        end
    end

    assign fault = fault_q;
    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: builds a per-cycle expected trace for each instruction
// from its class, wait counts and run value, then replays stimulus and compares every cycle.
module tb_multicycle_ctrl;

    localparam int T = 16;

    localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5, K_JAL = 6;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic clk = 1'b0;
    logic rst_n, run, alu_zero, mem_ready;
    logic [6:0] opcode;
    logic mem_req, mem_we, iord, ir_write, pc_write, alu_src, reg_write, retire, fault;
    logic [1:0] pc_src, alu_op, wb_sel;
    logic [2:0] state;
    logic [17:0] got_vec;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src),
        .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel), .retire(retire),
        .fault(fault), .state(state)
    );

    assign got_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src, alu_op,
                      reg_write, wb_sel, retire, fault, state};

    typedef struct packed {
        logic       run;
        logic       rdy;
        logic       az;
        logic [6:0] op;
    } stim_t;

    stim_t       stim_q[$];
    logic [17:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] mk(input logic [2:0] st, input logic mreq, input logic we,
                                       input logic io, input logic irw, input logic pcw,
                                       input logic [1:0] pcs, input logic as, input logic [1:0] aop,
                                       input logic rw, input logic [1:0] wbs, input logic ret,
                                       input logic flt);
        return {mreq, we, io, irw, pcw, pcs, as, aop, rw, wbs, ret, flt, st};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom_range(0, 127));
    endfunction

    function automatic int opclass(input logic [6:0] op);
        case (op)
            OP_R:  return K_R;
            OP_I:  return K_I;
            OP_LD: return K_LD;
            OP_ST: return K_ST;
            OP_BR: return K_BR;
`ifdef MULTICYCLE_JAL_EN
            OP_JAL: return K_JAL;
`endif
            default: return K_ILL;
        endcase
    endfunction

    task automatic push(input logic r, input logic rdy, input logic az, input logic [6:0] op,
                        input logic [17:0] e);
        stim_t s;
        s = {r, rdy, az, op};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic push_halt();
        for (int i = 0; i < 3; i++)
            push(rb(), rb(), rb(), rop(), mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 1));
    endtask

    task automatic push_start();
        push(1'b1, rb(), rb(), rop(), mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
    endtask

    // Expected trace of one instruction starting in its first FETCH cycle.
    task automatic gen(input logic [6:0] op, input int fw, input int mw, input logic az,
                       input logic run_after, output logic halted);
        int c;
        c = opclass(op);
        halted = 1'b0;
        for (int i = 0; i < fw && i <= T; i++)
            push(rb(), 1'b0, rb(), rop(), mk(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
        if (fw > T) begin
            push_halt();
            halted = 1'b1;
            return;
        end
        push(rb(), 1'b1, rb(), rop(), mk(3'd1, 1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
        push(rb(), rb(), rb(), op, mk(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
        if (c == K_ILL) begin
            push_halt();
            halted = 1'b1;
            return;
        end
        case (c)
            K_R, K_I: begin
                push(rb(), rb(), rb(), rop(),
                     mk(3'd3, 0, 0, 0, 0, 0, 2'b00, (c == K_I), 2'b10, 0, 2'b00, 0, 0));
                push(run_after, rb(), rb(), rop(),
                     mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 1, 0));
            end
            K_LD, K_ST: begin
                push(rb(), rb(), rb(), rop(), mk(3'd3, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0));
                for (int i = 0; i < mw && i <= T; i++)
                    push(rb(), 1'b0, rb(), rop(),
                         mk(3'd4, 1, (c == K_ST), 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
                if (mw > T) begin
                    push_halt();
                    halted = 1'b1;
                    return;
                end
                if (c == K_LD) begin
                    push(rb(), 1'b1, rb(), rop(), mk(3'd4, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
                    push(run_after, rb(), rb(), rop(),
                         mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b01, 1, 0));
                end else begin
                    push(run_after, 1'b1, rb(), rop(),
                         mk(3'd4, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 1, 0));
                end
            end
            K_BR: begin
                push(run_after, rb(), az, rop(), mk(3'd3, 0, 0, 0, 0, az, 2'b01, 0, 2'b01, 0, 2'b00, 1, 0));
            end
            default: begin
                push(rb(), rb(), rb(), rop(), mk(3'd3, 0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 0, 2'b00, 0, 0));
                push(run_after, rb(), rb(), rop(),
                     mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 1, 0));
            end
        endcase
        if (!run_after) begin
            for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                push(1'b0, rb(), rb(), rop(), mk(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
            push_start();
        end
    endtask

    task automatic play(input string tag);
        stim_t s;
        logic [17:0] e;
        int cyc;
        cyc = 0;
        while (exp_q.size() > 0) begin
            s = stim_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            run = s.run;
            mem_ready = s.rdy;
            alu_zero = s.az;
            opcode = s.op;
            #1;
            check($sformatf("%s cyc%0d", tag, cyc), 32'(got_vec), 32'(e));
            cyc++;
        end
    endtask

    // Reset lands mid-cycle, so the checks see its effect before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        run = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_outs", 32'(got_vec), 32'd0);
        @(negedge clk);
        check("rst_hold", 32'(got_vec), 32'd0);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [6:0] op, input int fw, input int mw, input logic az,
                        input logic ra, input string tag);
        logic h;
        gen(op, fw, mw, az, ra, h);
        play(tag);
        if (h) begin
            do_reset();
            push_start();
        end
    endtask

    initial begin
        logic [6:0] ops[6];
        logic [6:0] op;
        int fw, mw;
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LD;
        ops[3] = OP_ST; ops[4] = OP_BR; ops[5] = OP_JAL;
        rst_n = 1'b1;
        run = 1'b0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        opcode = 7'd0;

        do_reset();
        push_start();
        step(OP_R, 0, 0, 1'b0, 1'b1, "r_type");
        step(OP_LD, 0, 3, 1'b0, 1'b1, "load_wait3");
        step(OP_BR, 0, 0, 1'b1, 1'b1, "br_taken");
        step(OP_BR, 0, 0, 1'b0, 1'b1, "br_not_taken");
        step(OP_JAL, 0, 0, 1'b0, 1'b1, "jal");
        step(OP_ST, 1, 1, 1'b0, 1'b0, "store_run0");
        step(OP_I, 0, 0, 1'b0, 1'b1, "i_type");
        step(OP_R, T, 0, 1'b0, 1'b1, "fetch_edge");
        step(OP_LD, 0, T, 1'b0, 1'b1, "mem_edge");
        step(OP_R, T + 1, 0, 1'b0, 1'b1, "fetch_timeout");
        step(OP_ST, 0, T + 1, 1'b0, 1'b1, "mem_timeout");
        step(7'b0000000, 0, 0, 1'b0, 1'b1, "illegal");

        // Reset while a fetch request is outstanding.
        for (int i = 0; i < 3; i++)
            push(rb(), 1'b0, rb(), rop(), mk(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 0, 0));
        play("inflight");
        do_reset();
        push_start();

        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 9) == 0) ? rop() : ops[$urandom_range(0, 5)];
            fw = ($urandom_range(0, 14) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 14) == 0) ? T + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
            step(op, fw, mw, rb(), ($urandom_range(0, 3) != 0), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
